// File: rtl/mips_reg_file_byp.sv
// Two-read, one-write register file with per-byte write enables, optional
// same-cycle write forwarding, and a self-clearing start-up sequence.
module mips_reg_file_byp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ADDR_WIDTH-1:0]     raddr1,
  output logic [DATA_WIDTH-1:0]     rdata1,
  input  logic [ADDR_WIDTH-1:0]     raddr2,
  output logic [DATA_WIDTH-1:0]     rdata2,
  input  logic [DATA_WIDTH/8-1:0]   wen,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic                      ready,
  output logic                      wr_drop,
  output logic                      fsm_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic user_wr;
  logic user_wr_ok;

  assign user_wr    = (|wen) && (waddr != ADDR_ZERO);
  assign user_wr_ok = user_wr && (state == RUN);
  assign fsm_state  = state;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // FSM: CLEAR walks the pointer 1..DEPTH-1 exactly once, then RUN until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR;
      ptr     <= PTR_FIRST;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= (state != RUN) && user_wr;
      case (state)
        CLEAR: begin
          if (ptr == PTR_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          state <= RUN;
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; only the CLEAR walk zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (user_wr_ok) begin
      mem[waddr] <= merge_bytes(mem[waddr], wdata, wen);
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_word(
    input logic [ADDR_WIDTH-1:0] ra,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    if (state == RUN && ra != ADDR_ZERO) begin
      if (BYPASS != 0 && user_wr_ok && ra == waddr)
        res = merge_bytes(stored, wdata, wen);
      else
        res = stored;
    end
    return res;
  endfunction

  always_comb begin
    rdata1 = read_word(raddr1, mem[raddr1]);
    rdata2 = read_word(raddr2, mem[raddr2]);
  end

  a_ready_only_in_run: assert property (@(posedge clk) disable iff (!resetn)
    ready == (state == RUN));
  a_ptr_nonzero: assert property (@(posedge clk) disable iff (!resetn)
    ptr != ADDR_ZERO);

endmodule
